// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered UART transmitter: FIFO, baud divider and 8N1 framing FSM.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_buffered #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  if (DATA_BITS < 1 || CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_buffered: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_nx;
  state_t               state, state_nx;
  logic [BW-1:0]        baud;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 push, pop, txd_nx, baud_last, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (fifo_count == '0);
  assign baud_last  = (baud == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    shift_nx = shift;
    txd_nx   = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: if (baud_last) state_nx = S_DATA;
      S_DATA: begin
        if (baud_last) begin
          shift_nx = shift >> 1;
          if (bit_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_last) state_nx = S_STOP;
`endif
      S_STOP: begin
        // Chain straight into the next START so queued frames leave no idle bit.
        if (baud_last) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = S_START;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (pop) shift_nx = mem[rd_ptr];
    case (state_nx)
      S_START:  txd_nx = 1'b0;
      S_DATA:   txd_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_nx = par_bit;
`endif
      default:  txd_nx = 1'b1;
    endcase
  end

  always_comb begin
    count_nx = fifo_count;
    case ({push, pop})
      2'b10:   count_nx = fifo_count + CW'(1);
      2'b01:   count_nx = fifo_count - CW'(1);
      default: count_nx = fifo_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_ready   <= 1'b1;
      state      <= S_IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_nx;
      tx_ready   <= (count_nx < CW'(FIFO_DEPTH));
      state      <= state_nx;
      shift      <= shift_nx;
      txd        <= txd_nx;
      tx_busy    <= (state_nx != S_IDLE);
      if (state_nx != state || state == S_IDLE || baud_last) baud <= '0;
      else                                                    baud <= baud + BW'(1);
      if (state != S_DATA) bit_idx <= '0;
      else if (baud_last)  bit_idx <= bit_idx + IW'(1);
`ifdef UART_TX_PARITY_EN
      if (pop) par_bit <= (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard bench for uart_tx_buffered with a serial line receiver.
// Honours UART_TX_PARITY_EN for frame length and parity bit.
module tb_uart_tx_buffered;

  localparam int DB    = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CLKS = (DB + 3) * CPB;
`else
  localparam int FRAME_CLKS = (DB + 2) * CPB;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DB-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          tx_busy;
  logic [2:0]    fifo_count;

  int            cyc = 0;
  int            busy_cnt = 0;
  int            passed = 0;
  int            total = 0;
  logic [DB-1:0] sb [$];
  logic [DB-1:0] stim [8];
  int            exp_cnt [8];
  int            exp_rdy [8];

  uart_tx_buffered #(
    .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_busy) busy_cnt <= busy_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; drives n words on consecutive edges, the first nacc are expected accepted.
  task automatic drive(input string name, input int n, input int nacc);
    for (int i = 0; i < n; i++) begin
      tx_data  = stim[i];
      tx_valid = 1'b1;
      if (i < nacc) sb.push_back(stim[i]);
      @(negedge clk);
      check($sformatf("%s_count%0d", name, i), 32'(fifo_count), 32'(exp_cnt[i]));
      check($sformatf("%s_ready%0d", name, i), 32'(tx_ready), 32'(exp_rdy[i]));
    end
    tx_valid = 1'b0;
    tx_data  = '1;
  endtask

  task automatic rx_frames(input string name, input int n);
    int prev_start = 0;
    for (int f = 0; f < n; f++) begin
      int            t = 0;
      logic [DB-1:0] d = '0;
      logic [DB-1:0] e;
      while (txd !== 1'b0 && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) begin
        check($sformatf("%s_rx_timeout%0d", name, f), 32'd1, 32'd0);
        return;
      end
      if (f > 0) check($sformatf("%s_gap%0d", name, f), 32'(cyc - prev_start), 32'(FRAME_CLKS));
      prev_start = cyc;
      repeat (CPB / 2) @(negedge clk);
      check($sformatf("%s_start%0d", name, f), 32'(txd), 32'd0);
      for (int i = 0; i < DB; i++) begin
        repeat (CPB) @(negedge clk);
        d[i] = txd;
      end
      e = (sb.size() > 0) ? sb.pop_front() : 'x;
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      check($sformatf("%s_parity%0d", name, f), 32'(txd), 32'((^e) ^ PODD[0]));
`endif
      repeat (CPB) @(negedge clk);
      check($sformatf("%s_stop%0d", name, f), 32'(txd), 32'd1);
      check($sformatf("%s_data%0d", name, f), 32'(d), 32'(e));
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((tx_busy || fifo_count != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check({name, "_idle_timeout"}, 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int b0, t;
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame with push-to-start latency and tx_data capture.
    stim[0] = 8'hA5; exp_cnt[0] = 1; exp_rdy[0] = 1;
    b0 = busy_cnt;
    fork
      begin
        drive("single", 1, 1);
        check("lat_txd_n", 32'(txd), 32'd1);
        check("lat_busy_n", 32'(tx_busy), 32'd0);
        @(negedge clk);
        check("lat_txd_n1", 32'(txd), 32'd0);
        check("lat_busy_n1", 32'(tx_busy), 32'd1);
        check("lat_count_n1", 32'(fifo_count), 32'd0);
      end
      rx_frames("single", 1);
    join
    wait_idle("single");
    check("single_busy_len", 32'(busy_cnt - b0), 32'(FRAME_CLKS));

    // Back-to-back frames.
    stim[0] = 8'h00; stim[1] = 8'hFF; stim[2] = 8'h3C;
    exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2;
    for (int i = 0; i < 3; i++) exp_rdy[i] = 1;
    b0 = busy_cnt;
    fork
      drive("b2b", 3, 3);
      rx_frames("b2b", 3);
    join
    wait_idle("b2b");
    check("b2b_busy_len", 32'(busy_cnt - b0), 32'(3 * FRAME_CLKS));

    // Fill the FIFO; the sixth word must be dropped.
    for (int i = 0; i < 6; i++) stim[i] = 8'(8'h11 * (i + 1));
    exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 2; exp_cnt[3] = 3; exp_cnt[4] = 4; exp_cnt[5] = 4;
    exp_rdy[0] = 1; exp_rdy[1] = 1; exp_rdy[2] = 1; exp_rdy[3] = 1; exp_rdy[4] = 0; exp_rdy[5] = 0;
    b0 = busy_cnt;
    fork
      drive("full", 6, 5);
      rx_frames("full", 5);
    join
    wait_idle("full");
    check("full_busy_len", 32'(busy_cnt - b0), 32'(5 * FRAME_CLKS));
    check("full_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of DATA bit 3 of 0x81.
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while (txd !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rstmid_started", 32'(t < 100), 32'd1);
    repeat (CPB + 3 * CPB + CPB / 2) @(negedge clk);
    check("rstmid_busy_before", 32'(tx_busy), 32'd1);
    check("rstmid_txd_before", 32'(txd), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_txd", 32'(txd), 32'd1);
    check("rstmid_busy", 32'(tx_busy), 32'd0);
    check("rstmid_count", 32'(fifo_count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    stim[0] = 8'h55; exp_cnt[0] = 1; exp_rdy[0] = 1;
    b0 = busy_cnt;
    fork
      drive("post_rst", 1, 1);
      rx_frames("post_rst", 1);
    join
    wait_idle("post_rst");
    check("post_rst_busy_len", 32'(busy_cnt - b0), 32'(FRAME_CLKS));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
